redun_to_bin: RTL and testbench

//  Downstream stage of the redundant-form Montgomery squarer: converts its redundant output
//  (NUM_WRDS words, WRD_BITS+REDUN_BITS each, word i weighted 2^(WRD_BITS*i)) into plain binary.

---
 rtl/redun_to_bin.sv | 200 ++++++++++++++++++++
 tb/tb_redun_to_bin.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/redun_to_bin.sv
// redun_to_bin
// Converts the redundant output of the Montgomery squarer into plain binary.
// The input holds NUM_WRDS words of WRD_BITS+REDUN_BITS bits, and word i carries the
// weight 2^(WRD_BITS*i). The block resolves CHUNK words per cycle and keeps the carry
// in a register between chunks. At the same time it runs a borrow chain that subtracts
// the modulus. If reduction is enabled and the value is >= i_mod, the difference is
// selected as the result. Only one subtraction is ever made.
//
// Ports
//   i_clk     clock
//   i_rst     asynchronous active-high reset; aborts any conversion in flight
//   i_redun   redundant value, word 0 in the LSBs
//   i_mod     modulus for the conditional subtraction
//   i_red_en  1 = subtract i_mod when value >= i_mod
//   i_val     input valid, accepted when i_val & o_rdy
//   o_rdy     block idle
//   o_bin     binary result, held while o_val is high
//   o_ovf     nonzero bits of the result above OUT_BITS
//   o_val     result valid
//   i_rdy     downstream ready
//
// state | meaning
// IDLE  | waiting for a job; o_rdy=1
// CONV  | resolving one chunk per cycle (counter 0..NCHUNK-1)
// SEL   | choosing between the sum and the difference; registering the outputs
// DONE  | o_val=1, outputs held until i_rdy
module redun_to_bin #(
    parameter int NUM_WRDS   = 65,
    parameter int WRD_BITS   = 16,
    parameter int REDUN_BITS = 1,
    parameter int CHUNK      = 8
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic [NUM_WRDS*(WRD_BITS+REDUN_BITS)-1:0]   i_redun,
    input  logic [NUM_WRDS*WRD_BITS-1:0]                i_mod,
    input  logic                                        i_red_en,
    input  logic                                        i_val,
    output logic                                        o_rdy,
    output logic [NUM_WRDS*WRD_BITS-1:0]                o_bin,
    output logic                                        o_ovf,
    output logic                                        o_val,
    input  logic                                        i_rdy
);

    localparam int WR         = WRD_BITS + REDUN_BITS;
    localparam int NCHUNK     = (NUM_WRDS + CHUNK - 1) / CHUNK;
    localparam int OUT_BITS   = NUM_WRDS * WRD_BITS;
    localparam int IN_BITS    = NUM_WRDS * WR;
    localparam int CHUNK_BITS = CHUNK * WRD_BITS;
    localparam int CHUNK_IN   = CHUNK * WR;
    localparam int PAD_IN     = NCHUNK * CHUNK_IN;
    localparam int PAD_OUT    = NCHUNK * CHUNK_BITS;
    localparam int LAST_BITS  = (NUM_WRDS - (NCHUNK - 1) * CHUNK) * WRD_BITS;
    localparam int CARRY_W    = REDUN_BITS + 2;
    localparam int SUM_W      = CHUNK_BITS + CARRY_W;
    localparam int CNT_W      = $clog2(NCHUNK + 1);

    // The last chunk may be partial. Bits above LAST_BITS in that chunk lie past OUT_BITS,
    // so they belong in the carry and are masked out of X.
    localparam logic [CHUNK_BITS-1:0] LAST_MASK = {CHUNK_BITS{1'b1}} >> (CHUNK_BITS - LAST_BITS);

    typedef enum logic [1:0] {IDLE, CONV, SEL, DONE} state_t;

    state_t state_q, state_d;

    logic [PAD_IN-1:0]     redun_sh;
    logic [PAD_OUT-1:0]    mod_sh;
    logic [PAD_OUT-1:0]    x_sh;
    logic [PAD_OUT-1:0]    d_sh;
    logic [CARRY_W-1:0]    carry_q;
    logic                  borrow_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  red_en_q;

    logic [PAD_IN-1:0]     redun_pad;
    logic [PAD_OUT-1:0]    mod_pad;
    logic                  is_last;
    logic [SUM_W-1:0]      sum;
    logic [CHUNK_BITS-1:0] x_chunk;
    logic [CARRY_W-1:0]    carry_d;
    logic [CHUNK_BITS:0]   diff_full;
    logic                  sub;
    logic                  ovf_sel;

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_rdy   = 1'b0;
        o_val   = 1'b0;
        case (state_q)
            IDLE: begin
                o_rdy = 1'b1;
                if (i_val) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                    state_d = SEL;
                end
            end
            SEL: begin
                state_d = DONE;
            end
            DONE: begin
                o_val = 1'b1;
                if (i_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Chunk datapath: the sum chain and the difference chain, one chunk per cycle
    always_comb begin
        redun_pad              = '0;
        redun_pad[IN_BITS-1:0] = i_redun;
        mod_pad                = '0;
        mod_pad[OUT_BITS-1:0]  = i_mod;

        is_last = (cnt_q == CNT_W'(NCHUNK - 1));

        sum = SUM_W'(carry_q);
        for (int j = 0; j < CHUNK; j++) begin
            sum = sum + (SUM_W'(redun_sh[j*WR +: WR]) << (WRD_BITS * j));
        end

        x_chunk = sum[CHUNK_BITS-1:0];
        carry_d = sum[CHUNK_BITS +: CARRY_W];
        if (is_last) begin
            x_chunk = x_chunk & LAST_MASK;
            carry_d = sum[LAST_BITS +: CARRY_W];
        end

        diff_full = {1'b0, x_chunk} - {1'b0, mod_sh[CHUNK_BITS-1:0]} - (CHUNK_BITS + 1)'(borrow_q);

        // With a nonzero carry the value is at least 2^OUT_BITS, which is above any modulus.
        sub     = red_en_q & ((carry_q != '0) | ~borrow_q);
        ovf_sel = sub ? (carry_q != CARRY_W'(borrow_q)) : (carry_q != '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            redun_sh <= '0;
            mod_sh   <= '0;
            x_sh     <= '0;
            d_sh     <= '0;
            carry_q  <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            red_en_q <= 1'b0;
            o_bin    <= '0;
            o_ovf    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_val) begin
                        redun_sh <= redun_pad;
                        mod_sh   <= mod_pad;
                        red_en_q <= i_red_en;
                        carry_q  <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                CONV: begin
                    // Input registers shift down and result registers fill from the top,
                    // so chunk 0 lands at the LSBs after NCHUNK steps.
                    redun_sh <= redun_sh >> CHUNK_IN;
                    mod_sh   <= mod_sh >> CHUNK_BITS;
                    x_sh     <= (x_sh >> CHUNK_BITS) | (PAD_OUT'(x_chunk) << (PAD_OUT - CHUNK_BITS));
                    d_sh     <= (d_sh >> CHUNK_BITS)
                                | (PAD_OUT'(diff_full[CHUNK_BITS-1:0]) << (PAD_OUT - CHUNK_BITS));
                    carry_q  <= carry_d;
                    borrow_q <= diff_full[CHUNK_BITS];
                    cnt_q    <= cnt_q + 1'b1;
                end
                SEL: begin
                    o_bin <= sub ? d_sh[OUT_BITS-1:0] : x_sh[OUT_BITS-1:0];
                    o_ovf <= ovf_sel;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redun_to_bin.sv
module tb_redun_to_bin;

    localparam int NW    = 65;
    localparam int WB    = 16;
    localparam int WR    = 17;
    localparam int OUT_W = NW * WB;
    localparam int IN_W  = NW * WR;

    typedef struct {
        logic [OUT_W-1:0] bin;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [IN_W-1:0]  i_redun;
    logic [OUT_W-1:0] i_mod;
    logic             i_red_en;
    logic             i_val;
    logic             o_rdy;
    logic [OUT_W-1:0] o_bin;
    logic             o_ovf;
    logic             o_val;
    logic             i_rdy;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic [OUT_W-1:0] p_mod;

    redun_to_bin dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_redun  (i_redun),
        .i_mod    (i_mod),
        .i_red_en (i_red_en),
        .i_val    (i_val),
        .o_rdy    (o_rdy),
        .o_bin    (o_bin),
        .o_ovf    (o_ovf),
        .o_val    (o_val),
        .i_rdy    (i_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        int first;
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            first = -1;
            for (int i = OUT_W - 1; i >= 0; i--) begin
                if (act[i] !== exp[i]) first = i;
            end
            $display("FAIL %s: got ..%h expected ..%h (low 256 bits, first differing bit %0d)",
                     tag, act[255:0], exp[255:0], first);
        end
    endtask

    function automatic logic [IN_W-1:0] to_redun(input logic [OUT_W-1:0] v, input bit shuffle);
        logic [16:0]     w [NW];
        logic [IN_W-1:0] r;
        for (int i = 0; i < NW; i++) w[i] = {1'b0, v[i*WB +: WB]};
        if (shuffle) begin
            for (int i = 0; i < NW - 1; i++) begin
                if ($urandom_range(0, 1) == 1 && w[i+1] != 17'd0) begin
                    w[i+1] = w[i+1] - 17'd1;
                    w[i]   = w[i] + 17'h10000;
                end
            end
        end
        r = '0;
        for (int i = 0; i < NW; i++) r[i*WR +: WR] = w[i];
        return r;
    endfunction

    function automatic logic [OUT_W+1:0] from_redun(input logic [IN_W-1:0] r);
        logic [OUT_W+1:0] acc;
        acc = '0;
        for (int i = 0; i < NW; i++) acc = acc + ((OUT_W + 2)'(r[i*WR +: WR]) << (WB * i));
        return acc;
    endfunction

    function automatic logic [OUT_W-1:0] rand_1024();
        logic [OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Scoreboard: pops one expectation per handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst && o_val && i_rdy) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", OUT_W'(1), OUT_W'(0));
            end else begin
                e = sb_q.pop_front();
                chk("sb_bin", o_bin, e.bin);
                chk("sb_ovf", OUT_W'(o_ovf), OUT_W'(e.ovf));
            end
        end
    end

    task automatic start_job(input logic [IN_W-1:0] r, input logic [OUT_W-1:0] m, input logic en,
                             input logic [OUT_W-1:0] eb, input logic eo);
        int n;
        n = 0;
        while (!o_rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_rdy) chk("rdy_timeout", OUT_W'(o_rdy), OUT_W'(1));
        i_redun  = r;
        i_mod    = m;
        i_red_en = en;
        i_val    = 1'b1;
        sb_q.push_back('{bin: eb, ovf: eo});
        @(posedge clk); #1;
        i_val = 1'b0;
    endtask

    task automatic wait_val(output int lat);
        lat = 0;
        while (!o_val && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!o_val) chk("val_timeout", OUT_W'(o_val), OUT_W'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_val && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (o_val) chk("idle_timeout", OUT_W'(o_val), OUT_W'(0));
    endtask

    task automatic run_job(input logic [IN_W-1:0] r, input logic [OUT_W-1:0] m, input logic en,
                           input logic [OUT_W-1:0] eb, input logic eo, output int lat);
        start_job(r, m, en, eb, eo);
        wait_val(lat);
        wait_idle();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0]  r;
        logic [OUT_W-1:0] v;
        logic [OUT_W-1:0] hold;
        logic [OUT_W+1:0] full;
        int               lat;

        p_mod    = (OUT_W'(1) << 1024) - OUT_W'(159);
        rst      = 1'b1;
        i_redun  = '0;
        i_mod    = '0;
        i_red_en = 1'b0;
        i_val    = 1'b0;
        i_rdy    = 1'b1;
        #1;
        chk("rst_rdy", OUT_W'(o_rdy), OUT_W'(1));
        chk("rst_val", OUT_W'(o_val), OUT_W'(0));
        chk("rst_bin", o_bin, OUT_W'(0));
        chk("rst_ovf", OUT_W'(o_ovf), OUT_W'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // all zero: result 0, latency NCHUNK+1
        run_job('0, '0, 1'b0, '0, 1'b0, lat);
        chk("latency", OUT_W'(lat), OUT_W'(10));

        // a carry crosses the boundary between chunk 0 and chunk 1
        r = '0;
        r[7*WR +: WR] = 17'h10000;
        r[8*WR +: WR] = 17'h0FFFF;
        run_job(r, '0, 1'b0, OUT_W'(1) << 144, 1'b0, lat);

        // top word overflows past OUT_BITS
        r = '0;
        r[64*WR +: WR] = 17'h10000;
        run_job(r, '0, 1'b0, '0, 1'b1, lat);

        // conditional subtraction at the edges
        run_job(to_redun(p_mod + OUT_W'(5), 1'b1), p_mod, 1'b1, OUT_W'(5), 1'b0, lat);
        run_job(to_redun(p_mod, 1'b0), p_mod, 1'b1, '0, 1'b0, lat);
        run_job(to_redun(p_mod - OUT_W'(1), 1'b1), p_mod, 1'b1, p_mod - OUT_W'(1), 1'b0, lat);

        // stalled output, with i_val pulsed while busy
        i_rdy = 1'b0;
        v = rand_1024();
        start_job(to_redun(v, 1'b1), p_mod, 1'b0, v, 1'b0);
        wait_val(lat);
        hold = o_bin;
        for (int k = 0; k < 5; k++) begin
            chk("stall_bin", o_bin, hold);
            chk("stall_val", OUT_W'(o_val), OUT_W'(1));
            chk("stall_rdy", OUT_W'(o_rdy), OUT_W'(0));
            i_val   = (k == 2);
            i_redun = to_redun(rand_1024(), 1'b0);
            @(posedge clk); #1;
        end
        i_val = 1'b0;
        i_rdy = 1'b1;
        @(posedge clk); #1;
        chk("release_val", OUT_W'(o_val), OUT_W'(0));
        chk("release_rdy", OUT_W'(o_rdy), OUT_W'(1));
        run_job(to_redun(p_mod + OUT_W'(77), 1'b1), p_mod, 1'b1, OUT_W'(77), 1'b0, lat);
        chk("post_stall_lat", OUT_W'(lat), OUT_W'(10));

        // reset during chunk 4
        v = rand_1024();
        start_job(to_redun(v, 1'b1), '0, 1'b0, v, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_val", OUT_W'(o_val), OUT_W'(0));
        chk("abort_bin", o_bin, OUT_W'(0));
        chk("abort_rdy", OUT_W'(o_rdy), OUT_W'(1));
        sb_q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        v = rand_1024();
        run_job(to_redun(v, 1'b1), '0, 1'b0, v, 1'b0, lat);
        chk("post_rst_lat", OUT_W'(lat), OUT_W'(10));

        // random squarer outputs
        for (int t = 0; t < 1000; t++) begin
            if (t % 2 == 0) begin
                for (int i = 0; i < NW; i++) r[i*WR +: WR] = 17'($urandom);
                full = from_redun(r);
                run_job(r, p_mod, 1'b0, full[OUT_W-1:0], |full[OUT_W+1:OUT_W], lat);
            end else begin
                v = rand_1024();
                if (v >= p_mod) v = v - p_mod;
                hold = ($urandom_range(0, 1) == 1) ? v + p_mod : v;
                run_job(to_redun(hold, 1'b1), p_mod, 1'b1, v, 1'b0, lat);
            end
        end

        chk("sb_drained", OUT_W'(sb_q.size()), OUT_W'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
